// File: rtl/dsp_mac_array.sv
// Multi-lane signed multiply-accumulate engine with first/last vector framing and a global stall.
// Define DSP_MAC_SATURATE_EN to clamp results to OUT_W instead of wrapping.
module dsp_mac_array #(
    parameter int LANES      = 4,
    parameter int A_W        = 8,
    parameter int B_W        = 8,
    parameter int ACC_W      = 32,
    parameter int OUT_W      = 16,
    parameter int OUT_SHIFT  = 0,
    parameter int MUL_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [LANES*A_W-1:0]   in_a,
    input  logic [LANES*B_W-1:0]   in_b,
    input  logic                   in_first,
    input  logic                   in_last,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [LANES*OUT_W-1:0] out_data,
    output logic [LANES-1:0]       out_sat
);

    localparam int P_W = A_W + B_W;
    localparam int LAST = MUL_STAGES - 1;

    logic                   advance;
    logic [MUL_STAGES-1:0]  pv_q, pf_q, pl_q;
    logic [LANES*ACC_W-1:0] prod_in;
    logic [LANES*ACC_W-1:0] prod_q [MUL_STAGES];
    logic [LANES*ACC_W-1:0] acc_q, acc_d;
    logic                   done_q;
    logic                   out_valid_q;
    logic [LANES*OUT_W-1:0] out_data_q, out_data_d;
    logic [LANES-1:0]       out_sat_q, out_sat_d;

    assign advance   = !out_valid_q || out_ready;
    assign in_ready  = advance && !rst;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sat   = out_sat_q;

    // done_q marks that acc_q holds a finished vector sum awaiting transfer to the output
    // register; the next beat then starts from zero regardless of its first flag.
    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            logic signed [A_W-1:0]   a_s;
            logic signed [B_W-1:0]   b_s;
            logic signed [P_W-1:0]   p_s;
            logic        [ACC_W-1:0] acc_l;
            logic        [ACC_W-1:0] base;
            logic        [ACC_W-1:0] sum;

            assign a_s = in_a[gi*A_W +: A_W];
            assign b_s = in_b[gi*B_W +: B_W];
            assign p_s = P_W'(a_s) * P_W'(b_s);
            assign prod_in[gi*ACC_W +: ACC_W] = ACC_W'(p_s);

            assign acc_l = acc_q[gi*ACC_W +: ACC_W];
            assign base  = (pf_q[LAST] || done_q) ? '0 : acc_l;
            assign sum   = base + prod_q[LAST][gi*ACC_W +: ACC_W];

            always_comb begin
                acc_d[gi*ACC_W +: ACC_W] = acc_l;
                if (pv_q[LAST]) begin
                    acc_d[gi*ACC_W +: ACC_W] = sum;
                end else if (done_q) begin
                    acc_d[gi*ACC_W +: ACC_W] = '0;
                end
            end

`ifdef DSP_MAC_SATURATE_EN
            localparam logic signed [ACC_W-1:0] MAX_V = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
            localparam logic signed [ACC_W-1:0] MIN_V = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};
            logic signed [ACC_W-1:0] shifted;

            assign shifted = $signed(acc_l) >>> OUT_SHIFT;

            always_comb begin
                out_data_d[gi*OUT_W +: OUT_W] = shifted[OUT_W-1:0];
                out_sat_d[gi]                 = 1'b0;
                if (shifted > MAX_V) begin
                    out_data_d[gi*OUT_W +: OUT_W] = MAX_V[OUT_W-1:0];
                    out_sat_d[gi]                 = 1'b1;
                end else if (shifted < MIN_V) begin
                    out_data_d[gi*OUT_W +: OUT_W] = MIN_V[OUT_W-1:0];
                    out_sat_d[gi]                 = 1'b1;
                end
            end
`else
            // Arithmetic shift followed by truncation is just a slice of the accumulator.
            assign out_data_d[gi*OUT_W +: OUT_W] = acc_l[OUT_SHIFT +: OUT_W];
            assign out_sat_d[gi]                 = 1'b0;
`endif
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            pv_q <= '0;
            pf_q <= '0;
            pl_q <= '0;
            for (int s = 0; s < MUL_STAGES; s++) begin
                prod_q[s] <= '0;
            end
        end else if (advance) begin
            pv_q[0]   <= in_valid;
            pf_q[0]   <= in_first;
            pl_q[0]   <= in_last;
            prod_q[0] <= prod_in;
            for (int s = 1; s < MUL_STAGES; s++) begin
                pv_q[s]   <= pv_q[s-1];
                pf_q[s]   <= pf_q[s-1];
                pl_q[s]   <= pl_q[s-1];
                prod_q[s] <= prod_q[s-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q       <= '0;
            done_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sat_q   <= '0;
        end else if (advance) begin
            acc_q       <= acc_d;
            done_q      <= pv_q[LAST] && pl_q[LAST];
            out_valid_q <= done_q;
            if (done_q) begin
                out_data_q <= out_data_d;
                out_sat_q  <= out_sat_d;
            end
        end
    end

endmodule

// File: tb/tb_dsp_mac_array.sv
// Scoreboard bench for dsp_mac_array: directed vectors, expected results queued at issue time
// and popped by independent output monitors.
module tb_dsp_mac_array;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_first, in_last, out_ready, sel2;
    logic [31:0] in_a, in_b;
    logic        v1, v2, r1, r2, ov1, ov2;
    logic [63:0] od1, od2;
    logic [3:0]  os1, os2;

    always #5 clk = ~clk;

    assign v1 = in_valid && !sel2;
    assign v2 = in_valid && sel2;

    dsp_mac_array dut (
        .clk(clk), .rst(rst), .in_valid(v1), .in_ready(r1),
        .in_a(in_a), .in_b(in_b), .in_first(in_first), .in_last(in_last),
        .out_valid(ov1), .out_ready(out_ready), .out_data(od1), .out_sat(os1)
    );

    dsp_mac_array #(.OUT_SHIFT(4)) dut_sh (
        .clk(clk), .rst(rst), .in_valid(v2), .in_ready(r2),
        .in_a(in_a), .in_b(in_b), .in_first(in_first), .in_last(in_last),
        .out_valid(ov2), .out_ready(1'b1), .out_data(od2), .out_sat(os2)
    );

    typedef struct {
        logic [63:0] d;
        logic [3:0]  s;
    } exp_t;

    exp_t q1[$];
    exp_t q2[$];
    int   pops[$];
    int   checks = 0;
    int   fails  = 0;
    int   cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] pack8(input int x0, input int x1, input int x2, input int x3);
        return {x3[7:0], x2[7:0], x1[7:0], x0[7:0]};
    endfunction

    function automatic logic [63:0] pack16(input int x0, input int x1, input int x2, input int x3);
        return {x3[15:0], x2[15:0], x1[15:0], x0[15:0]};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push1(input logic [63:0] d, input logic [3:0] s);
        exp_t e;
        e.d = d;
        e.s = s;
        q1.push_back(e);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (ov1 && out_ready) begin
            if (q1.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_result: got %h expected none", od1);
            end else begin
                e = q1.pop_front();
                chk("result_data", od1, e.d);
                chk("result_sat", {60'd0, os1}, {60'd0, e.s});
                pops.push_back(cyc);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (ov2) begin
            if (q2.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected_shift_result: got %h expected none", od2);
            end else begin
                e = q2.pop_front();
                chk("shift_data", od2, e.d);
                chk("shift_sat", {60'd0, os2}, {60'd0, e.s});
            end
        end
    end

    task automatic beat(input logic [31:0] a, input logic [31:0] b, input logic f, input logic l);
        bit ok;
        int n;
        in_a = a;
        in_b = b;
        in_first = f;
        in_last = l;
        in_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            ok = sel2 ? r2 : r1;
            @(posedge clk);
            #1;
            n++;
        end while (!ok && n < 200);
        if (!ok) begin
            checks++;
            fails++;
            $display("FAIL beat_accept: got timeout expected in_ready");
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q1.size() != 0 || q2.size() != 0) && n < 2000) begin
            @(posedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        if (q1.size() != 0 || q2.size() != 0) begin
            checks++;
            fails++;
            $display("FAIL drain: got %0d pending expected 0", q1.size() + q2.size());
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int          lat;
        int          base;
        logic [31:0] ones;
        logic [31:0] p127;
        exp_t        e;

        rst = 1'b1;
        in_valid = 1'b0;
        in_first = 1'b0;
        in_last = 1'b0;
        out_ready = 1'b1;
        sel2 = 1'b0;
        in_a = '0;
        in_b = '0;
        ones = pack8(1, 1, 1, 1);
        p127 = pack8(127, 127, 127, 127);

        // reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_out_valid", {63'd0, ov1}, 64'd0);
        chk("reset_in_ready", {63'd0, r1}, 64'd0);
        chk("reset_out_data", od1, 64'd0);
        chk("reset_out_sat", {60'd0, os1}, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // single-beat vector and latency
        push1(pack16(15, -24, -127, 16384), 4'h0);
        beat(pack8(3, -4, 127, -128), pack8(5, 6, -1, -128), 1'b1, 1'b1);
        lat = 0;
        do begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end while (!ov1 && lat < 20);
        chk("latency", 64'(lat), 64'd3);
        drain();

        // four-beat vector with a bubble between beats 1 and 2
        push1(pack16(4, 4, 4, 4), 4'h0);
        beat(ones, ones, 1'b1, 1'b0);
        beat(ones, ones, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        beat(ones, ones, 1'b0, 1'b0);
        beat(ones, ones, 1'b0, 1'b1);
        drain();

        // 300 x 127*127 = 4838700
`ifdef DSP_MAC_SATURATE_EN
        push1(pack16(32767, 32767, 32767, 32767), 4'hF);
`else
        push1(pack16(-10964, -10964, -10964, -10964), 4'h0);
`endif
        for (int i = 0; i < 300; i++) begin
            beat(p127, p127, i == 0, i == 299);
        end
        drain();

        // output stall: result held, next beat blocked
        out_ready = 1'b0;
        push1(pack16(2, 4, 6, 8), 4'h0);
        beat(pack8(1, 2, 3, 4), pack8(2, 2, 2, 2), 1'b1, 1'b1);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!ov1 && lat < 20);
        push1(pack16(5, 6, 7, 8), 4'h0);
        in_a = pack8(5, 6, 7, 8);
        in_b = ones;
        in_first = 1'b1;
        in_last = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_in_ready", {63'd0, r1}, 64'd0);
            chk("stall_out_valid", {63'd0, ov1}, 64'd1);
            chk("stall_out_data", od1, pack16(2, 4, 6, 8));
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        beat(pack8(5, 6, 7, 8), ones, 1'b1, 1'b1);
        drain();

        // back-to-back single-beat vectors stream one result per cycle
        base = pops.size();
        for (int k = 1; k <= 8; k++) begin
            push1(pack16(k, -k, 2 * k, 3 * k), 4'h0);
            beat(pack8(k, -k, 2 * k, 3), pack8(1, 1, 1, k), 1'b1, 1'b1);
        end
        drain();
        chk("stream_count", 64'(pops.size() - base), 64'd8);
        if (pops.size() - base == 8) begin
            chk("stream_spacing", 64'(pops[pops.size() - 1] - pops[pops.size() - 8]), 64'd7);
        end

        // reset mid-vector discards the partial sum
        beat(pack8(3, 3, 3, 3), pack8(3, 3, 3, 3), 1'b1, 1'b0);
        beat(pack8(3, 3, 3, 3), pack8(3, 3, 3, 3), 1'b0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_in_ready", {63'd0, r1}, 64'd0);
        chk("midrst_out_valid", {63'd0, ov1}, 64'd0);
        @(negedge clk);
        chk("postrst_out_valid", {63'd0, ov1}, 64'd0);
        rst = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        push1(pack16(4, 4, 4, 4), 4'h0);
        beat(pack8(2, 2, 2, 2), pack8(2, 2, 2, 2), 1'b1, 1'b1);
        // first=0 right after a completed vector starts from zero
        push1(pack16(1, 1, 1, 1), 4'h0);
        beat(ones, ones, 1'b0, 1'b1);
        drain();

        // OUT_SHIFT=4 instance
        sel2 = 1'b1;
        e.d = pack16(625, -625, 1, -1);
        e.s = 4'h0;
        q2.push_back(e);
        beat(pack8(100, -100, 16, -1), pack8(100, 100, 1, 1), 1'b1, 1'b1);
        sel2 = 1'b0;
        drain();

        chk("scoreboard_empty", 64'(q1.size() + q2.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
